// File: rtl/seg_scan_driver_if.sv
// ============================================================================
// Module   : seg_frame_if
// Purpose  : Frame handshake between the game core (master) and the segment
//            scan driver (slave): one full frame of per-digit segment bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_frame_if #(
    parameter int NUM_DIGITS = 6
);
    logic [NUM_DIGITS*8-1:0] frame_data;
    logic                    frame_valid;
    logic                    frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Double-buffered, tear-free time-multiplexed 7-segment scan
//            driver. Frames arrive over a valid/ready handshake and are
//            swapped into the displayed buffer only at a scan-frame boundary.
// Options  : define SEG_SCAN_BRIGHTNESS_EN to add a 4-bit brightness input
//            and a free-running PWM gate on the segment lines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  wire                   clk,
    input  wire                   rst,
    seg_frame_if.slave            frame_if,
`ifdef SEG_SCAN_BRIGHTNESS_EN
    input  wire  [3:0]            brightness,
`endif
    output logic                  frame_start,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  segA,
    output logic                  segB,
    output logic                  segC,
    output logic                  segD,
    output logic                  segE,
    output logic                  segF,
    output logic                  segG,
    output logic                  segDP
);

    // One counter serves both BLANK and SHOW, so it is sized for the longer.
    localparam int c_CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_DIG_W   = $clog2(NUM_DIGITS);

    localparam logic [c_CNT_W-1:0]    c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_SHOW_LAST  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_DIG_W-1:0]    c_DIG_LAST   = c_DIG_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE        = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                         state_q;
    logic [NUM_DIGITS-1:0][7:0]     pending_q;
    logic [NUM_DIGITS-1:0][7:0]     active_q;
    logic                           pend_full_q;
    logic                           pend_full_d;
    logic                           ready_q;
    logic [c_DIG_W-1:0]             digit_q;
    logic [c_CNT_W-1:0]             cnt_q;
    logic                           frame_start_q;
    logic [NUM_DIGITS-1:0]          dig_en_q;
    logic [7:0]                     segs_q;

    logic                           w_accept;
    logic                           w_wrap;
    logic                           w_swap;
    logic                           w_gate;
    logic [7:0]                     w_segs;

`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0] pwm_q;
    logic [3:0] pwm_d;

    // Free-running PWM phase counter for brightness gating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Gate uses the counter value that will be current while the registered
    // segments are on the pins; 15 means always on.
    always_comb begin
        pwm_d  = pwm_q + 4'd1;
        w_gate = (brightness == 4'hF) || (pwm_d < brightness);
    end
`else
    assign w_gate = 1'b1;
`endif

    // Handshake and buffer-swap decisions; accept and swap never coincide
    // because a full pending buffer holds ready low.
    always_comb begin
        w_accept    = frame_if.frame_valid && ready_q;
        w_wrap      = (state_q == S_SHOW) && (cnt_q == c_SHOW_LAST) && (digit_q == c_DIG_LAST);
        w_swap      = pend_full_q && ((state_q == S_IDLE) || w_wrap);
        pend_full_d = (pend_full_q || w_accept) && !w_swap;
        w_segs      = active_q[digit_q] & {8{w_gate}};
    end

    // Scan state machine, buffers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            active_q      <= '0;
            pend_full_q   <= 1'b0;
            ready_q       <= 1'b1;
            digit_q       <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            dig_en_q      <= '0;
            segs_q        <= '0;
        end else begin
            frame_start_q <= 1'b0;
            pend_full_q   <= pend_full_d;
            ready_q       <= !pend_full_d;
            if (w_accept) begin
                pending_q <= frame_if.frame_data;
            end
            if (w_swap) begin
                active_q <= pending_q;
            end

            case (state_q)
                S_IDLE: begin
                    dig_en_q <= '0;
                    segs_q   <= '0;
                    if (pend_full_q) begin
                        state_q       <= S_BLANK;
                        digit_q       <= '0;
                        cnt_q         <= '0;
                        frame_start_q <= 1'b1;
                    end
                end
                S_BLANK: begin
                    if (cnt_q == c_BLANK_LAST) begin
                        state_q  <= S_SHOW;
                        cnt_q    <= '0;
                        dig_en_q <= c_ONE << digit_q;
                        segs_q   <= w_segs;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == c_SHOW_LAST) begin
                        state_q  <= S_BLANK;
                        cnt_q    <= '0;
                        dig_en_q <= '0;
                        segs_q   <= '0;
                        if (digit_q == c_DIG_LAST) begin
                            digit_q       <= '0;
                            frame_start_q <= 1'b1;
                        end else begin
                            digit_q <= digit_q + 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        segs_q <= w_segs;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    dig_en_q <= '0;
                    segs_q   <= '0;
                end
            endcase
        end
    end

    assign frame_if.frame_ready = ready_q;
    assign frame_start          = frame_start_q;
    assign dig_en               = dig_en_q;
    assign segA                 = segs_q[0];
    assign segB                 = segs_q[1];
    assign segC                 = segs_q[2];
    assign segD                 = segs_q[3];
    assign segE                 = segs_q[4];
    assign segF                 = segs_q[5];
    assign segG                 = segs_q[6];
    assign segDP                = segs_q[7];

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Self-checking bench for seg_scan_driver (6 digits, 4 lit cycles,
//            1 blank cycle) against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;
    localparam int ND  = 6;
    localparam int SD  = 4;
    localparam int BC  = 1;
    localparam int SLOT = BC + SD;
    localparam int PER = ND * SLOT;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic [ND-1:0] dig_en;
    logic segA, segB, segC, segD, segE, segF, segG, segDP;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0] brightness = 4'hF;
`endif

    seg_frame_if #(.NUM_DIGITS(ND)) fif ();

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_if   (fif),
`ifdef SEG_SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .frame_start(frame_start),
        .dig_en     (dig_en),
        .segA       (segA),
        .segB       (segB),
        .segC       (segC),
        .segD       (segD),
        .segE       (segE),
        .segF       (segF),
        .segG       (segG),
        .segDP      (segDP)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: frame position is derived from the cycle count since
    // the first frame_start; buffers are plain variables.
    bit          m_started;
    int          m_t;
    bit          m_pf;
    logic [47:0] m_pend;
    logic [47:0] m_act;

    function automatic logic [7:0] segs_now();
        return {segDP, segG, segF, segE, segD, segC, segB, segA};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_t       = 0;
        m_pf      = 1'b0;
        m_pend    = '0;
        m_act     = '0;
    endtask

    task automatic model_step();
        bit acc;
        acc = fif.frame_valid && !m_pf;
        if (!m_started) begin
            if (m_pf) begin
                m_started = 1'b1;
                m_t       = 0;
                m_act     = m_pend;
                m_pf      = 1'b0;
            end
        end else begin
            m_t++;
            if ((m_t % PER) == 0 && m_pf) begin
                m_act = m_pend;
                m_pf  = 1'b0;
            end
        end
        if (acc) begin
            m_pend = fif.frame_data;
            m_pf   = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int p, dig;
        bit lit;
        logic [ND-1:0] e_en;
        logic [7:0]    e_seg;
        p     = m_t % PER;
        dig   = p / SLOT;
        lit   = m_started && ((p % SLOT) >= BC);
        e_en  = lit ? (ND'(1) << dig) : '0;
        e_seg = lit ? m_act[dig*8 +: 8] : 8'h00;
        chk("frame_ready", fif.frame_ready, !m_pf);
        chk("frame_start", frame_start, m_started && (p == 0));
        chk("dig_en", dig_en, e_en);
        chk("segs", segs_now(), e_seg);
        chk("onehot", ($countones(dig_en) <= 1), 1'b1);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step();
        check_outputs();
    endtask

    task automatic send(input logic [47:0] data);
        bit done;
        done = 1'b0;
        fif.frame_data  = data;
        fif.frame_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            done = !m_pf;
            cycle();
        end
        fif.frame_valid = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    initial begin
        bit found;
        model_reset();
        rst             = 1'b1;
        fif.frame_valid = 1'b0;
        fif.frame_data  = '0;
        repeat (3) cycle();
        rst = 1'b0;

        // Idle after reset: nothing lit, ready high, no frame_start.
        repeat (20) cycle();

        // Known frame, one-cycle valid, then more than one scan frame.
        send(48'h3F065B4F666D);
        repeat (34) cycle();

        // Frame B mid-scan lands in pending; C stalls until the next wrap.
        send(rand48());
        send(rand48());
        repeat (40) cycle();

        // Valid held high with changing data across several scan frames.
        fif.frame_valid = 1'b1;
        repeat (3 * PER) begin
            fif.frame_data = rand48();
            cycle();
        end
        fif.frame_valid = 1'b0;
        repeat (2 * PER) cycle();

        // Asynchronous reset while digit 3 is lit.
        found = 1'b0;
        for (int i = 0; i < 2 * PER && !found; i++) begin
            if (m_started && ((m_t % PER) / SLOT) == 3 && ((m_t % PER) % SLOT) >= BC)
                found = 1'b1;
            else
                cycle();
        end
        chk("reach_digit3", found, 1'b1);
        chk("digit3_lit", dig_en, 6'b001000);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_dig_en", dig_en, '0);
        chk("rst_segs", segs_now(), 8'h00);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_ready", fif.frame_ready, 1'b1);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        repeat (15) cycle();

        // New frame after reset, then randomized traffic.
        send(rand48());
        repeat (40) cycle();
        repeat (400) begin
            fif.frame_valid = ($urandom_range(0, 3) == 0);
            fif.frame_data  = rand48();
            cycle();
        end
        fif.frame_valid = 1'b0;
        repeat (PER) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

`default_nettype wire
